// File: rtl/core_pkg.sv
// Shared types for the Adelie core: access sizes, LSU states and byte-enable patterns.
package core_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } lsu_state_e;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/core_lsu_align.sv
// Lane steering for the LSU: store byte enables / lane replication and
// load lane extraction with sign or zero extension. Purely combinational.
module core_lsu_align
    import core_pkg::*;
(
    input  size_e       st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  st_be,
    output logic [31:0] st_lanes,
    input  size_e       ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_sign,
    input  logic [31:0] ld_raw,
    output logic [31:0] ld_data
);

    logic [1:0]  ld_eff;
    logic [31:0] ld_shift;

    always_comb begin
        st_be    = BE_WORD;
        st_lanes = st_data;
        case (st_size)
            SZ_BYTE: begin
                st_be    = BE_BYTE << st_off;
                st_lanes = {4{st_data[7:0]}};
            end
            SZ_HALF: begin
                st_be    = BE_HALF << {st_off[1], 1'b0};
                st_lanes = {2{st_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Half accesses ignore ADDR[0]; words always start at lane 0.
    always_comb begin
        ld_eff = 2'b00;
        case (ld_size)
            SZ_BYTE: ld_eff = ld_off;
            SZ_HALF: ld_eff = {ld_off[1], 1'b0};
            default: ld_eff = 2'b00;
        endcase
        ld_shift = ld_raw >> {ld_eff, 3'b000};
        ld_data  = ld_shift;
        case (ld_size)
            SZ_BYTE: ld_data = {{24{ld_sign & ld_shift[7]}}, ld_shift[7:0]};
            SZ_HALF: ld_data = {{16{ld_sign & ld_shift[15]}}, ld_shift[15:0]};
            default: ld_data = ld_shift;
        endcase
    end

endmodule

// File: rtl/core_lsu.sv
// Load/store unit: single-beat req/gnt + rvalid data bus master with registered outputs.
// Optional CORE_LSU_MISALIGN_TRAP_EN: misaligned half/word accesses complete without a bus cycle.
//
// state   | meaning
// IDLE    | waiting for START with a valid access type
// REQ     | D_REQ high, bus fields stable, waiting for D_GNT
// WAIT    | load granted, waiting for D_RVALID
// DONE    | one-cycle completion pulse
module core_lsu
    import core_pkg::*;
(
    input  logic        RST_N,
    input  logic        CLK,
    input  logic        START,
    input  logic        I_LB,
    input  logic        I_LH,
    input  logic        I_LW,
    input  logic        I_LBU,
    input  logic        I_LHU,
    input  logic        I_SB,
    input  logic        I_SH,
    input  logic        I_SW,
    input  logic [31:0] ADDR,
    input  logic [31:0] WDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic [31:0] RDATA,
    output logic        MISALIGN,
    output logic        D_REQ,
    output logic        D_WE,
    output logic [31:0] D_ADDR,
    output logic [3:0]  D_BE,
    output logic [31:0] D_WDATA,
    input  logic        D_GNT,
    input  logic        D_RVALID,
    input  logic [31:0] D_RDATA
);

    lsu_state_e  state, state_nxt;
    size_e       dec_size, lat_size;
    logic        dec_valid, dec_sign, dec_store;
    logic        lat_sign, lat_store;
    logic [1:0]  lat_off;
    logic        accept, trap;
    logic [3:0]  be_comb;
    logic [31:0] lanes_comb, ld_ext;

    always_comb begin
        dec_valid = 1'b1;
        dec_size  = SZ_BYTE;
        dec_sign  = 1'b0;
        dec_store = 1'b0;
        if (I_LB) begin
            dec_sign = 1'b1;
        end else if (I_LH) begin
            dec_size = SZ_HALF;
            dec_sign = 1'b1;
        end else if (I_LW) begin
            dec_size = SZ_WORD;
        end else if (I_LBU) begin
            dec_size = SZ_BYTE;
        end else if (I_LHU) begin
            dec_size = SZ_HALF;
        end else if (I_SB) begin
            dec_store = 1'b1;
        end else if (I_SH) begin
            dec_size  = SZ_HALF;
            dec_store = 1'b1;
        end else if (I_SW) begin
            dec_size  = SZ_WORD;
            dec_store = 1'b1;
        end else begin
            dec_valid = 1'b0;
        end
    end

`ifdef CORE_LSU_MISALIGN_TRAP_EN
    assign trap = ((dec_size == SZ_HALF) && ADDR[0]) ||
                  ((dec_size == SZ_WORD) && (ADDR[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    assign accept = (state == ST_IDLE) && START && dec_valid;

    core_lsu_align u_align (
        .st_size  (dec_size),
        .st_off   (ADDR[1:0]),
        .st_data  (WDATA),
        .st_be    (be_comb),
        .st_lanes (lanes_comb),
        .ld_size  (lat_size),
        .ld_off   (lat_off),
        .ld_sign  (lat_sign),
        .ld_raw   (D_RDATA),
        .ld_data  (ld_ext)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept) state_nxt = trap ? ST_DONE : ST_REQ;
            ST_REQ:  if (D_GNT) state_nxt = lat_store ? ST_DONE : ST_WAIT;
            ST_WAIT: if (D_RVALID) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state     <= ST_IDLE;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
            D_REQ     <= 1'b0;
            D_WE      <= 1'b0;
            D_ADDR    <= '0;
            D_BE      <= '0;
            D_WDATA   <= '0;
            RDATA     <= '0;
            lat_size  <= SZ_BYTE;
            lat_sign  <= 1'b0;
            lat_store <= 1'b0;
            lat_off   <= 2'b00;
        end else begin
            state <= state_nxt;
            BUSY  <= (state_nxt != ST_IDLE);
            DONE  <= (state_nxt == ST_DONE);
            D_REQ <= (state_nxt == ST_REQ);
            if (accept) begin
                lat_size  <= dec_size;
                lat_sign  <= dec_sign;
                lat_store <= dec_store;
                lat_off   <= ADDR[1:0];
                if (!trap) begin
                    D_WE    <= dec_store;
                    D_ADDR  <= {ADDR[31:2], 2'b00};
                    D_BE    <= be_comb;
                    D_WDATA <= lanes_comb;
                end
            end
            if ((state == ST_WAIT) && D_RVALID) begin
                RDATA <= ld_ext;
            end
        end
    end

`ifdef CORE_LSU_MISALIGN_TRAP_EN
    logic mis_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            mis_q <= 1'b0;
        end else begin
            mis_q <= accept && trap;
        end
    end

    assign MISALIGN = mis_q;
`else
    assign MISALIGN = 1'b0;
`endif

endmodule
